// File: rtl/halut_pkg.sv
// Shared HALUT dimensions and derived widths for the decoder datapath.
package halut_pkg;

  localparam int unsigned K             = 16;
  localparam int unsigned C             = 32;
  localparam int unsigned DataTypeWidth = 16;
  localparam int unsigned TreeDepth     = $clog2(K);
  localparam int unsigned CAddrWidth    = $clog2(C);
  // Summing C signed entries needs at most log2(C) extra bits.
  localparam int unsigned AccWidth      = DataTypeWidth + CAddrWidth;
  localparam int unsigned LutAddrWidth  = $clog2(C * K);

endpackage

// File: rtl/scm.sv
// Standard-cell memory holding one LUT column: synchronous write, combinational read.
module scm #(
  parameter int unsigned C             = 32,
  parameter int unsigned K             = 16,
  parameter int unsigned DataTypeWidth = 16,
  localparam int unsigned AddrWidth    = $clog2(C * K)
) (
  input  logic                     clk_i,
  input  logic [AddrWidth-1:0]     waddr_i,
  input  logic [DataTypeWidth-1:0] wdata_i,
  input  logic                     we_i,
  input  logic [AddrWidth-1:0]     raddr_i,
  output logic [DataTypeWidth-1:0] rdata_o
);

  logic [DataTypeWidth-1:0] mem_q [C*K];

  // A read of the address being written returns the old contents this cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/halut_decoder.sv
// HALUT decoder: accumulates one LUT entry per codebook over C codes and emits the row sum.
module halut_decoder
  import halut_pkg::*;
#(
  parameter int unsigned K              = halut_pkg::K,
  parameter int unsigned C              = halut_pkg::C,
  parameter int unsigned DataTypeWidth  = halut_pkg::DataTypeWidth,
  localparam int unsigned TreeDepth     = $clog2(K),
  localparam int unsigned CAddrWidth    = $clog2(C),
  localparam int unsigned AccWidth      = DataTypeWidth + CAddrWidth,
  localparam int unsigned LutAddrWidth  = $clog2(C * K)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [LutAddrWidth-1:0]  waddr_i,
  input  logic [DataTypeWidth-1:0] wdata_i,
  input  logic                     we_i,
  input  logic                     decoder_i,
  input  logic [CAddrWidth-1:0]    c_addr_i,
  input  logic [TreeDepth-1:0]     k_addr_i,
  input  logic                     valid_i,
  output logic [AccWidth-1:0]      result_o,
  output logic                     valid_o,
  output logic [15:0]              row_cnt_o
);

  localparam logic [CAddrWidth-1:0] LastCnt = CAddrWidth'(C - 1);

  logic [DataTypeWidth-1:0] rdata;
  logic [DataTypeWidth-1:0] rdata_q, rdata_d;
  logic                     vld_q, vld_d;
  logic                     last_q, last_d;
  logic                     first_q, first_d;
  logic                     dec_q, dec_d;
  logic [CAddrWidth-1:0]    cnt_q, cnt_d;
  logic [AccWidth-1:0]      acc_q, acc_d;
  logic [AccWidth-1:0]      result_d;
  logic                     valid_d;
  logic [15:0]              row_cnt_d;
  logic [AccWidth-1:0]      sum;

  scm #(
    .C             (C),
    .K             (K),
    .DataTypeWidth (DataTypeWidth)
  ) lut_memory (
    .clk_i   (clk_i),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i),
    .we_i    (we_i),
    .raddr_i ({c_addr_i, k_addr_i}),
    .rdata_o (rdata)
  );

  always_comb begin
    rdata_d   = rdata;
    vld_d     = valid_i & decoder_i;
    last_d    = vld_d & (cnt_q == LastCnt);
    first_d   = (cnt_q == '0);
    dec_d     = decoder_i;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_o;
    valid_d   = 1'b0;
    row_cnt_d = row_cnt_o;

    sum = (first_q ? '0 : acc_q) + {{CAddrWidth{rdata_q[DataTypeWidth-1]}}, rdata_q};

    if (!decoder_i) begin
      cnt_d = '0;
    end else if (valid_i) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    end

    // A row already in S1 completes even if decoder_i has just dropped.
    if (vld_q && last_q) begin
      result_d  = sum;
      valid_d   = 1'b1;
      acc_d     = '0;
      row_cnt_d = row_cnt_o + 16'd1;
    end else if (!decoder_i) begin
      acc_d = '0;
    end else if (vld_q) begin
      acc_d = sum;
    end

    if (decoder_i && !dec_q) begin
      row_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q   <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      first_q   <= 1'b0;
      dec_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      result_o  <= '0;
      valid_o   <= 1'b0;
      row_cnt_o <= '0;
    end else begin
      rdata_q   <= rdata_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      first_q   <= first_d;
      dec_q     <= dec_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      result_o  <= result_d;
      valid_o   <= valid_d;
      row_cnt_o <= row_cnt_d;
    end
  end

endmodule

// File: tb/tb_halut_decoder.sv
// Scoreboard bench for halut_decoder: row sums predicted from a LUT array model.
module tb_halut_decoder;

  localparam int C = 32;
  localparam int K = 16;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic [8:0]         waddr_i = '0;
  logic [15:0]        wdata_i = '0;
  logic               we_i = 1'b0;
  logic               decoder_i = 1'b0;
  logic [4:0]         c_addr_i = '0;
  logic [3:0]         k_addr_i = '0;
  logic               valid_i = 1'b0;
  logic signed [20:0] result_o;
  logic               valid_o;
  logic [15:0]        row_cnt_o;

  halut_decoder dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .we_i      (we_i),
    .decoder_i (decoder_i),
    .c_addr_i  (c_addr_i),
    .k_addr_i  (k_addr_i),
    .valid_i   (valid_i),
    .result_o  (result_o),
    .valid_o   (valid_o),
    .row_cnt_o (row_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int sum;
    int rows;
    int at_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: the LUT contents and the row in progress.
  int lut_m [C][K];
  int cnt_m = 0;
  int sum_m = 0;
  int rows_m = 0;
  bit dec_prev_m = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_o", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_o", int'(result_o), e.sum);
        check("row_cnt_o", int'(row_cnt_o), e.rows);
        check("latency_cycle", cyc, e.at_cyc);
      end
    end
  end

  // One clock of stimulus; the model reads the LUT before applying the write.
  task automatic step(input bit we, input int c_w, input int k_w, input int data,
                      input bit dec, input bit vld, input int c, input int k);
    @(negedge clk_i);
    we_i      = we;
    waddr_i   = 9'(c_w * K + k_w);
    wdata_i   = 16'(data);
    decoder_i = dec;
    valid_i   = vld;
    c_addr_i  = 5'(c);
    k_addr_i  = 4'(k);
    @(posedge clk_i);
    #1;
    if (dec && !dec_prev_m) rows_m = 0;
    if (!dec) begin
      cnt_m = 0;
      sum_m = 0;
    end else if (vld) begin
      sum_m += lut_m[c][k];
      cnt_m++;
      if (cnt_m == C) begin
        exp_t e;
        rows_m = (rows_m + 1) % 65536;
        e.sum = sum_m;
        e.rows = rows_m;
        e.at_cyc = cyc + 1;
        sb.push_back(e);
        cnt_m = 0;
        sum_m = 0;
      end
    end
    dec_prev_m = dec;
    if (we) lut_m[c_w][k_w] = data;
    we_i    = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, decoder_i, 0, 0, 0);
  endtask

  task automatic fill_lut(input int mode);
    for (int c = 0; c < C; c++)
      for (int k = 0; k < K; k++)
        step(1, c, k, (mode == 0) ? c + 1 :
                      (mode == 1) ? -1 : int'($urandom_range(0, 65535)) - 32768,
             decoder_i, 0, 0, 0);
  endtask

  task automatic send_row(input int k, input bit gaps, input bit shuffle);
    int order [C];
    for (int i = 0; i < C; i++) order[i] = i;
    if (shuffle) begin
      for (int i = C - 1; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
    end
    for (int i = 0; i < C; i++) begin
      step(0, 0, 0, 0, 1, 1, order[i], (k < 0) ? $urandom_range(0, K - 1) : k);
      if (gaps) idle($urandom_range(0, 3));
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_result_o"}, int'(result_o), 0);
    check({tag, "_valid_o"}, int'(valid_o), 0);
    check({tag, "_row_cnt_o"}, int'(row_cnt_o), 0);
  endtask

  initial begin
    #12;
    check_outputs_zero("reset");
    rst_ni = 1'b1;

    // 1: LUT[c][k] = c+1, one contiguous row.
    fill_lut(0);
    decoder_i = 1'b1;
    send_row(5, 0, 0);
    drain();

    // 2: two back-to-back rows of -1 entries.
    fill_lut(1);
    send_row(5, 0, 0);
    send_row(5, 0, 0);
    drain();

    // 3: gaps and shuffled codebook order.
    fill_lut(0);
    send_row(5, 1, 1);
    drain();

    // 4: partial row discarded when decoder_i drops.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 1, i, 5);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, i, 5);
    send_row(5, 0, 0);
    drain();

    // 5: write {3,5}=100 in the same cycle it is read.
    for (int i = 0; i < C; i++) step(i == 3, 3, 5, 100, 1, 1, i, 5);
    send_row(5, 0, 0);
    drain();
    step(1, 3, 5, 4, 1, 0, 0, 0);

    // 6: asynchronous reset mid-row.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 1, i, 5);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("midrow_reset");
    #2;
    rst_ni = 1'b1;
    cnt_m = 0;
    sum_m = 0;
    rows_m = 0;
    dec_prev_m = 0;
    sb.delete();
    send_row(5, 0, 0);
    drain();

    // Random LUT contents, random k and gaps.
    fill_lut(2);
    for (int r = 0; r < 4; r++) send_row(-1, r[0], 1);
    drain();
    idle(5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
